// File: rtl/srt4_pkg.sv
// srt4_pkg: shared types and constants for the radix-4 SRT divider controller.
//   state_t     - sequencer states
//   C_*         - bit index of each control strobe in c[15:0]
//   digit_t     - quotient digit chosen in QSEL
//   QSEL_T_*    - p_top thresholds (signed) that separate the digit bands
//   qsel_strobes / add_strobes - strobe words emitted for a digit in QSEL / ADD
package srt4_pkg;

  typedef enum logic [3:0] {
    IDLE, INIT, LOADB, NORM, QSEL, ADD, CORR, CONV, DENORM, DONE
  } state_t;

  localparam int C_INIT   = 0;   // P cleared, A loaded with dividend
  localparam int C_LOADB  = 1;   // load B
  localparam int C_NORM   = 2;   // shift P:A and B left 1
  localparam int C_SHIFT2 = 3;   // shift P:A left 2
  localparam int C_QP1    = 4;
  localparam int C_QM1    = 5;
  localparam int C_QM2    = 6;
  localparam int C_QP2    = 7;
  localparam int C_LOADP  = 8;   // load P from adder
  localparam int C_SUB    = 9;   // adder subtracts
  localparam int C_TWOB   = 10;  // adder uses 2B
  localparam int C_CORR   = 11;  // correction add B
  localparam int C_QDEC   = 12;  // quotient decrement
  localparam int C_CONV   = 13;  // A <= A - A'
  localparam int C_DENORM = 14;  // shift P right 1
  localparam int C_END    = 15;

  typedef enum logic [2:0] {QP2, QP1, Q0, QM1, QM2} digit_t;

  localparam int QSEL_T_P2 = 4;
  localparam int QSEL_T_P1 = 1;
  localparam int QSEL_T_Z  = -1;
  localparam int QSEL_T_M1 = -4;

  function automatic logic [15:0] qsel_strobes(digit_t d);
    logic [15:0] s;
    s = '0;
    s[C_SHIFT2] = 1'b1;
    case (d)
      QP2:     s[C_QP2] = 1'b1;
      QP1:     s[C_QP1] = 1'b1;
      QM1:     s[C_QM1] = 1'b1;
      QM2:     s[C_QM2] = 1'b1;
      default: ;
    endcase
    return s;
  endfunction

  // Positive digits subtract a multiple of B, negative digits add it.
  function automatic logic [15:0] add_strobes(digit_t d);
    logic [15:0] s;
    s = '0;
    case (d)
      QP2: begin s[C_LOADP] = 1'b1; s[C_SUB] = 1'b1; s[C_TWOB] = 1'b1; end
      QP1: begin s[C_LOADP] = 1'b1; s[C_SUB] = 1'b1; end
      QM1: s[C_LOADP] = 1'b1;
      QM2: begin s[C_LOADP] = 1'b1; s[C_TWOB] = 1'b1; end
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/srt4_qsel.sv
// srt4_qsel: combinational quotient-digit selection from the top bits of P.
//   p_top [3:0]  in   top 4 bits of P, two's complement
//   digit [2:0]  out  selected digit, encoded as srt4_pkg::digit_t
module srt4_qsel
  import srt4_pkg::*;
(
  input  logic [3:0] p_top,
  output logic [2:0] digit
);

  int pt;
  assign pt = int'($signed(p_top));

  always_comb begin
    digit = QM2;
    if (pt >= QSEL_T_P2)      digit = QP2;
    else if (pt >= QSEL_T_P1) digit = QP1;
    else if (pt >= QSEL_T_Z)  digit = Q0;
    else if (pt >= QSEL_T_M1) digit = QM1;
  end

endmodule

// File: rtl/srt4_ctrl_unit.sv
// srt4_ctrl_unit: control sequencer for the radix-4 SRT divider datapath.
//   clk, rst       in   clock (rising edge), async active-high reset
//   start          in   begin a division (only looked at in IDLE)
//   b_msb          in   B[WIDTH-1]; 1 = B normalised
//   p_top [3:0]    in   top bits of P, two's complement
//   p_sign         in   sign of the partial remainder
//   c [15:0]       out  control strobes, all registered
//   busy           out  division in progress
//   done           out  one-cycle pulse with c[15]
//   div_zero       out  B never normalised; held until the next start
//
// All outputs are registered from the current state, so each strobe appears
// in the cycle after the state that produced it. The datapath uses the strobes
// as register clocks, so its response is settled before the next FSM sample.
//
//   state  | meaning
//   IDLE   | wait for start
//   INIT   | c0, clear shift and iteration counters
//   LOADB  | c1
//   NORM   | c2 per left shift of B until b_msb, or give up (div_zero)
//   QSEL   | c3 + digit strobe from p_top, latch digit
//   ADD    | adder strobes for latched digit, count iteration
//   CORR   | negative remainder: c11|c8|c12
//   CONV   | c13, then undo normalisation if any
//   DENORM | c14 once per normalisation shift
//   DONE   | c15 + done
module srt4_ctrl_unit
  import srt4_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ITERS = 4,
  parameter int CNTW  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        b_msb,
  input  logic [3:0]  p_top,
  input  logic        p_sign,
  output logic [15:0] c,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  localparam int IW = $clog2(ITERS + 1);
  localparam logic [CNTW-1:0] K_MAX = CNTW'(WIDTH - 1);
  localparam logic [CNTW-1:0] K_ONE = CNTW'(1);
  localparam logic [IW-1:0]   I_END = IW'(ITERS);

  state_t          state, state_nxt;
  logic [CNTW-1:0] k, k_nxt;
  logic [IW-1:0]   iter, iter_nxt;
  digit_t          dig_q, dig_nxt;
  logic            dz_flag, dz_flag_nxt;
  logic [15:0]     c_nxt;
  logic            busy_nxt, done_nxt, div_zero_nxt;
  logic [2:0]      qsel_digit;

  srt4_qsel u_qsel (
    .p_top (p_top),
    .digit (qsel_digit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      k        <= '0;
      iter     <= '0;
      dig_q    <= Q0;
      dz_flag  <= 1'b0;
      c        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state    <= state_nxt;
      k        <= k_nxt;
      iter     <= iter_nxt;
      dig_q    <= dig_nxt;
      dz_flag  <= dz_flag_nxt;
      c        <= c_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      div_zero <= div_zero_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    k_nxt        = k;
    iter_nxt     = iter;
    dig_nxt      = dig_q;
    dz_flag_nxt  = dz_flag;
    c_nxt        = '0;
    busy_nxt     = 1'b1;
    done_nxt     = 1'b0;
    div_zero_nxt = div_zero;

    case (state)
      IDLE: begin
        busy_nxt = start;
        if (start) begin
          state_nxt    = INIT;
          div_zero_nxt = 1'b0;
        end
      end
      INIT: begin
        c_nxt[C_INIT] = 1'b1;
        k_nxt         = '0;
        iter_nxt      = '0;
        dz_flag_nxt   = 1'b0;
        state_nxt     = LOADB;
      end
      LOADB: begin
        c_nxt[C_LOADB] = 1'b1;
        state_nxt      = NORM;
      end
      NORM: begin
        if (b_msb) begin
          state_nxt = QSEL;
        end else if (k == K_MAX) begin
          dz_flag_nxt = 1'b1;
          state_nxt   = DONE;
        end else begin
          c_nxt[C_NORM] = 1'b1;
          k_nxt         = k + K_ONE;
        end
      end
      QSEL: begin
        dig_nxt   = digit_t'(qsel_digit);
        c_nxt     = qsel_strobes(digit_t'(qsel_digit));
        state_nxt = ADD;
      end
      ADD: begin
        c_nxt     = add_strobes(dig_q);
        iter_nxt  = iter + 1'b1;
        state_nxt = (iter_nxt < I_END) ? QSEL : CORR;
      end
      CORR: begin
        if (p_sign) begin
          c_nxt[C_CORR]  = 1'b1;
          c_nxt[C_LOADP] = 1'b1;
          c_nxt[C_QDEC]  = 1'b1;
        end
        state_nxt = CONV;
      end
      CONV: begin
        c_nxt[C_CONV] = 1'b1;
        // No normalisation shifts means nothing to undo: skip DENORM.
        state_nxt = (k == '0) ? DONE : DENORM;
      end
      DENORM: begin
        c_nxt[C_DENORM] = 1'b1;
        k_nxt           = k - K_ONE;
        if (k == K_ONE) state_nxt = DONE;
      end
      DONE: begin
        c_nxt[C_END] = 1'b1;
        done_nxt     = 1'b1;
        busy_nxt     = 1'b0;
        div_zero_nxt = dz_flag;
        state_nxt    = IDLE;
      end
      default: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_srt4_ctrl_unit.sv
module tb_srt4_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        b_msb;
  logic [3:0]  p_top;
  logic        p_sign;
  logic [15:0] c;
  logic        busy, done, div_zero;

  srt4_ctrl_unit #(.WIDTH(8), .ITERS(4), .CNTW(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .b_msb    (b_msb),
    .p_top    (p_top),
    .p_sign   (p_sign),
    .c        (c),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Datapath stand-in: B becomes normalised after nk_s left shifts; p_top
  // for iteration j is pv[j], where j = number of c3 shifts seen so far.
  int nk_s = 0;
  int pv [4];
  int c2cnt = 0;
  int c3cnt = 0;
  assign b_msb = (c2cnt >= nk_s);
  assign p_top = 4'(pv[(c3cnt < 4) ? c3cnt : 3]);

  always @(negedge clk) begin
    if (c[2]) c2cnt++;
    if (c[3]) c3cnt++;
  end

  // Expected per-cycle outputs, index t = cycles after the start edge.
  logic [15:0] exp_c    [64];
  logic        exp_busy [64];
  logic        exp_done [64];
  logic        exp_dz   [64];
  logic [15:0] cap_c    [64];
  int          end_t;
  int          tidx = 0;
  bit          chk_en = 1'b0;

  task automatic chk(string name, int t, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s t=%0d got=%0h want=%0h", name, t, act, want);
    end
  endtask

  function automatic logic [15:0] qsel_word(int p);
    if (p >= 4)  return 16'h0088;
    if (p >= 1)  return 16'h0018;
    if (p >= -1) return 16'h0008;
    if (p >= -4) return 16'h0028;
    return 16'h0048;
  endfunction

  function automatic logic [15:0] add_word(int p);
    if (p >= 4)  return 16'h0700;
    if (p >= 1)  return 16'h0300;
    if (p >= -1) return 16'h0000;
    if (p >= -4) return 16'h0100;
    return 16'h0500;
  endfunction

  task automatic build_model(int nk, bit ps);
    int  m;
    int  base;
    bit  dz;
    dz = (nk > 7);
    m  = dz ? 7 : nk;
    for (int t = 0; t < 64; t++) begin
      exp_c[t] = '0; exp_busy[t] = 1'b0; exp_done[t] = 1'b0;
      exp_dz[t] = 1'b0; cap_c[t] = '0;
    end
    exp_c[1] = 16'h0001;
    exp_c[2] = 16'h0002;
    for (int j = 0; j < m; j++) exp_c[3 + j] = 16'h0004;
    if (dz) begin
      end_t = 4 + m;
    end else begin
      base = 4 + m;
      for (int j = 0; j < 4; j++) begin
        exp_c[base + 2*j]     = qsel_word(pv[j]);
        exp_c[base + 2*j + 1] = add_word(pv[j]);
      end
      exp_c[base + 8] = ps ? 16'h1900 : 16'h0000;
      exp_c[base + 9] = 16'h2000;
      for (int j = 0; j < m; j++) exp_c[base + 10 + j] = 16'h4000;
      end_t = base + 10 + m;
    end
    exp_c[end_t]    = 16'h8000;
    exp_done[end_t] = 1'b1;
    for (int t = 0; t < end_t; t++) exp_busy[t] = 1'b1;
    exp_dz[end_t]     = dz;
    exp_dz[end_t + 1] = dz;
  endtask

  always @(negedge clk) begin
    if (chk_en && tidx < 64) begin
      cap_c[tidx] = c;
      chk("c",        tidx, 32'(c),        32'(exp_c[tidx]));
      chk("busy",     tidx, 32'(busy),     32'(exp_busy[tidx]));
      chk("done",     tidx, 32'(done),     32'(exp_done[tidx]));
      chk("div_zero", tidx, 32'(div_zero), 32'(exp_dz[tidx]));
      tidx++;
    end
  end

  task automatic start_run(int nk, int p0, int p1, int p2, int p3, bit ps);
    @(negedge clk); #1;
    nk_s = nk;
    pv[0] = p0; pv[1] = p1; pv[2] = p2; pv[3] = p3;
    p_sign = ps;
    c2cnt = 0; c3cnt = 0;
    build_model(nk, ps);
    start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    tidx   = 0;
    chk_en = 1'b1;
  endtask

  task automatic finish_run(bit noise);
    for (int t = 0; t <= end_t + 1; t++) begin
      @(negedge clk); #1;
      start = (noise && (t + 1 < end_t)) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start  = 1'b0;
    chk_en = 1'b0;
  endtask

  function automatic int count_bit(int b);
    int n;
    n = 0;
    for (int t = 0; t < 64; t++) if (cap_c[t][b]) n++;
    return n;
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; p_sign = 1'b0;
    pv[0] = 0; pv[1] = 0; pv[2] = 0; pv[3] = 0;
    #12;
    chk("rst_c",        0, 32'(c),        32'h0);
    chk("rst_busy",     0, 32'(busy),     32'h0);
    chk("rst_done",     0, 32'(done),     32'h0);
    chk("rst_div_zero", 0, 32'(div_zero), 32'h0);
    @(negedge clk); rst = 1'b0;

    // Abort in ADD while c8 is high.
    start_run(0, 5, 5, 5, 5, 1'b0);
    for (int t = 0; t <= 5; t++) @(negedge clk);
    #2;
    chk_en = 1'b0;
    chk("abort_pre_c", 5, 32'(c), 32'h0700);
    rst = 1'b1;
    #1;
    chk("abort_c",    5, 32'(c),    32'h0);
    chk("abort_busy", 5, 32'(busy), 32'h0);
    chk("abort_done", 5, 32'(done), 32'h0);
    @(negedge clk); rst = 1'b0;

    // Normalised B, zero digits, no correction.
    start_run(0, 0, 0, 0, 0, 1'b0);
    finish_run(1'b0);
    chk("s1_c0",  1,  32'(cap_c[1]),  32'h0001);
    chk("s1_c1",  2,  32'(cap_c[2]),  32'h0002);
    chk("s1_c3a", 4,  32'(cap_c[4]),  32'h0008);
    chk("s1_c3d", 10, 32'(cap_c[10]), 32'h0008);
    chk("s1_c13", 13, 32'(cap_c[13]), 32'h2000);
    chk("s1_c15", 14, 32'(cap_c[14]), 32'h8000);
    chk("s1_no_c8", 0, 32'(count_bit(8)), 32'd0);

    // Three normalisation shifts.
    start_run(3, 0, 0, 0, 0, 1'b0);
    finish_run(1'b0);
    chk("s3_c2_cnt",  0,  32'(count_bit(2)),  32'd3);
    chk("s3_c14_cnt", 0,  32'(count_bit(14)), 32'd3);
    chk("s3_c15",     20, 32'(cap_c[20]),     32'h8000);

    // One of each non-zero digit.
    start_run(0, 5, 2, -3, -6, 1'b0);
    finish_run(1'b0);
    chk("s4_q0", 4,  32'(cap_c[4]),  32'h0088);
    chk("s4_a0", 5,  32'(cap_c[5]),  32'h0700);
    chk("s4_q1", 6,  32'(cap_c[6]),  32'h0018);
    chk("s4_a1", 7,  32'(cap_c[7]),  32'h0300);
    chk("s4_q2", 8,  32'(cap_c[8]),  32'h0028);
    chk("s4_a2", 9,  32'(cap_c[9]),  32'h0100);
    chk("s4_q3", 10, 32'(cap_c[10]), 32'h0048);
    chk("s4_a3", 11, 32'(cap_c[11]), 32'h0500);

    // Remainder correction.
    start_run(0, 0, 0, 0, 0, 1'b1);
    finish_run(1'b0);
    chk("s5_corr", 12, 32'(cap_c[12]), 32'h1900);
    chk("s5_conv", 13, 32'(cap_c[13]), 32'h2000);

    // B never normalises; start pulses while busy.
    start_run(8, 0, 0, 0, 0, 1'b0);
    finish_run(1'b1);
    chk("s6_c2_cnt", 0,  32'(count_bit(2)), 32'd7);
    chk("s6_no_c3",  0,  32'(count_bit(3)), 32'd0);
    chk("s6_c15",    11, 32'(cap_c[11]),    32'h8000);
    chk("s6_dz",     0,  32'(div_zero),     32'h1);

    // Randomised divisions.
    for (int r = 0; r < 40; r++) begin
      start_run(int'($urandom_range(0, 8)),
                int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8,
                int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8,
                1'($urandom_range(0, 1)));
      finish_run(1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
